// File: rtl/zprize_mul_collect.sv
// Collection stage behind the fixed-latency multiplier: FIFO capture,
// valid/ready output stream and issue-credit return to the operand issuer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_i                  one operation injected upstream this cycle
//   can_issue_o, credit_o    registered credit availability / free count
//   mul_valid_i/out_i/m_i    multiplier result, product and sideband
//   out_valid_o/ready_i      output stream handshake
//   out_data_o, out_m_o      head product and sideband
//   count_o                  FIFO occupancy
//   err_o                    sticky credit-underflow / FIFO-overflow flag
module zprize_mul_collect #(
  parameter int W0 = 384,
  parameter int W1 = 384,
  parameter int M  = 32,
  parameter int D  = 8,
  parameter int CW = $clog2(D + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_i,
  output logic                 can_issue_o,
  output logic [CW-1:0]        credit_o,
  input  logic                 mul_valid_i,
  input  logic [W0+W1-1:0]     mul_out_i,
  input  logic [M-1:0]         mul_m_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [W0+W1-1:0]     out_data_o,
  output logic [M-1:0]         out_m_o,
  output logic [CW-1:0]        count_o,
  output logic                 err_o
);

  localparam int P  = W0 + W1;
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] DC = CW'(D);

  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] count_q, count_d;
  logic          can_q, can_d;
  logic          err_q, err_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;

  logic [P-1:0]  data_q [D];
  logic [M-1:0]  meta_q [D];

  logic pop, full, push, ovf, unf;

  always_comb begin
    pop  = (count_q != '0) & out_ready_i;
    full = (count_q == DC);
    // A full FIFO still accepts a push when the head leaves this cycle.
    push = mul_valid_i & (~full | pop);
    ovf  = mul_valid_i & full & ~pop;
    unf  = issue_i & (credit_q == '0);

    credit_d = credit_q;
    case ({issue_i, pop})
      2'b10: if (credit_q != '0) credit_d = credit_q - CW'(1);
      2'b01: if (credit_q != DC) credit_d = credit_q + CW'(1);
      // Issue against zero credit saturates; the pop still returns one.
      2'b11: if (credit_q == '0) credit_d = CW'(1);
      default: ;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase

    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    can_d = (credit_d != '0);
    err_d = err_q | ovf | unf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= DC;
      count_q  <= '0;
      can_q    <= 1'b1;
      err_q    <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      credit_q <= credit_d;
      count_q  <= count_d;
      can_q    <= can_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= mul_out_i;
      meta_q[wr_q] <= mul_m_i;
    end
  end

  assign can_issue_o = can_q;
  assign credit_o    = credit_q;
  assign count_o     = count_q;
  assign err_o       = err_q;
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = data_q[rd_q];
  assign out_m_o     = meta_q[rd_q];

endmodule
